pspin_cmd_dispatcher: RTL and testbench

//  Per-cluster command dispatcher: takes pspin_cmd_t from NUM_REQ HPUs and steers each one by

---
 rtl/pspin_cmd_dispatcher_pkg.sv | 32 +++
 rtl/pspin_cmd_fifo.sv | 47 ++++
 rtl/pspin_cmd_dispatcher.sv | 133 +++++++++++++
 tb/tb_pspin_cmd_dispatcher.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pspin_cmd_dispatcher_pkg.sv
// Shared configuration and command/response types for the cluster command dispatcher.
// Pure types and constants; no logic.
package pspin_cmd_dispatcher_pkg;

  localparam int NUM_CORES          = 8;
  localparam int NUM_CMD_INTERFACES = 3;
  localparam int NUM_HPU_CMDS       = 4;
  localparam int DISP_FIFO_DEPTH    = 4;

  localparam int CORE_ID_W  = 4;
  localparam int LOCAL_ID_W = 4;
  localparam int INTF_ID_W  = 2;

  typedef logic [$clog2(NUM_HPU_CMDS+1)-1:0] inflight_cnt_t;

  typedef struct packed {
    logic [CORE_ID_W-1:0]  core_id;
    logic [LOCAL_ID_W-1:0] local_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t         cmd_id;
    logic [INTF_ID_W-1:0]  intf_id;
    logic [31:0]           data;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [31:0]   imm_data;
  } pspin_cmd_resp_t;

endpackage

// File: rtl/pspin_cmd_fifo.sv
// Registered-storage FIFO; push visible on head_o the cycle after it is written.
// Full blocks push (even with a concurrent pop); head_o reads 0 while empty.
module pspin_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           do_push, do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? T'('0) : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/pspin_cmd_dispatcher.sv
// Steers HPU commands by intf_id into per-interface FIFOs (dispatch >=1 cycle after accept)
// and merges completions into a registered response pulse; per-HPU in-flight limit gates ready.
module pspin_cmd_dispatcher import pspin_cmd_dispatcher_pkg::*; #(
  parameter int NUM_REQ      = NUM_CORES,
  parameter int NUM_INTF     = NUM_CMD_INTERFACES,
  parameter int MAX_INFLIGHT = NUM_HPU_CMDS,
  parameter int FIFO_DEPTH   = DISP_FIFO_DEPTH,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT+1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               cmd_valid_i,
  output logic [NUM_REQ-1:0]               cmd_ready_o,
  input  pspin_cmd_t [NUM_REQ-1:0]         cmd_i,
  output logic [NUM_INTF-1:0]              intf_valid_o,
  input  logic [NUM_INTF-1:0]              intf_ready_i,
  output pspin_cmd_t [NUM_INTF-1:0]        intf_cmd_o,
  input  logic [NUM_INTF-1:0]              cmpl_valid_i,
  output logic [NUM_INTF-1:0]              cmpl_ready_o,
  input  pspin_cmd_resp_t [NUM_INTF-1:0]   cmpl_i,
  output logic                             resp_valid_o,
  output pspin_cmd_resp_t                  resp_o,
  output logic [NUM_REQ-1:0][CNT_W-1:0]    inflight_o,
  output logic                             err_o
);

  localparam int RPW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IPW = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;
  localparam int NID = 2**INTF_ID_W;

  logic [RPW-1:0]      req_ptr, req_win;
  logic [IPW-1:0]      cmpl_ptr, cmpl_win;
  logic                req_found, cmpl_found;
  logic [NUM_REQ-1:0]  req_elig, intf_bad, cnt_inc, cmpl_dec;
  logic [NUM_INTF-1:0] fifo_full, fifo_empty, fifo_push;
  logic [NID-1:0]      full_ext;
  logic                cmpl_bad;
  pspin_cmd_resp_t     cmpl_sel;

  // Out-of-range intf_id indexes a zero pad, so the lookup stays in bounds.
  assign full_ext = NID'(fifo_full);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      intf_bad[i] = int'(cmd_i[i].intf_id) >= NUM_INTF;
      req_elig[i] = cmd_valid_i[i] && (intf_bad[i] ||
                    (int'(inflight_o[i]) < MAX_INFLIGHT && !full_ext[cmd_i[i].intf_id]));
    end
  end

  always_comb begin
    req_found = 1'b0;
    req_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!req_found && req_elig[(int'(req_ptr) + k) % NUM_REQ]) begin
        req_found = 1'b1;
        req_win   = RPW'((int'(req_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    cmpl_found = 1'b0;
    cmpl_win   = '0;
    for (int k = 0; k < NUM_INTF; k++) begin
      if (!cmpl_found && cmpl_valid_i[(int'(cmpl_ptr) + k) % NUM_INTF]) begin
        cmpl_found = 1'b1;
        cmpl_win   = IPW'((int'(cmpl_ptr) + k) % NUM_INTF);
      end
    end
  end

  assign cmd_ready_o  = req_found  ? (NUM_REQ'(1)  << req_win)  : '0;
  assign cmpl_ready_o = cmpl_found ? (NUM_INTF'(1) << cmpl_win) : '0;
  assign cmpl_sel     = cmpl_i[cmpl_win];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i]  = req_found && (int'(req_win) == i) && !intf_bad[i];
      cmpl_dec[i] = cmpl_found && (int'(cmpl_sel.cmd_id.core_id) == i) && (inflight_o[i] != '0);
    end
    for (int k = 0; k < NUM_INTF; k++) begin
      fifo_push[k] = req_found && (int'(cmd_i[req_win].intf_id) == k);
    end
  end

  // A completion nobody owns (bad core_id or zero in-flight) is still forwarded.
  assign cmpl_bad = cmpl_found && (cmpl_dec == '0);

  for (genvar k = 0; k < NUM_INTF; k++) begin : g_fifo
    pspin_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (pspin_cmd_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push[k]),
      .data_i  (cmd_i[req_win]),
      .pop_i   (intf_valid_o[k] && intf_ready_i[k]),
      .full_o  (fifo_full[k]),
      .empty_o (fifo_empty[k]),
      .head_o  (intf_cmd_o[k])
    );
    assign intf_valid_o[k] = !fifo_empty[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ptr      <= '0;
      cmpl_ptr     <= '0;
      resp_valid_o <= 1'b0;
      resp_o       <= '0;
      err_o        <= 1'b0;
      inflight_o   <= '0;
    end else begin
      if (req_found)
        req_ptr <= (int'(req_win) == NUM_REQ-1) ? '0 : req_win + RPW'(1);
      if (cmpl_found) begin
        cmpl_ptr <= (int'(cmpl_win) == NUM_INTF-1) ? '0 : cmpl_win + IPW'(1);
        resp_o   <= cmpl_sel;
      end
      resp_valid_o <= cmpl_found;
      err_o        <= (req_found && intf_bad[req_win]) || cmpl_bad;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cmpl_dec[i])
          inflight_o[i] <= inflight_o[i] + CNT_W'(1);
        else if (!cnt_inc[i] && cmpl_dec[i])
          inflight_o[i] <= inflight_o[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pspin_cmd_dispatcher.sv
// Bench for pspin_cmd_dispatcher: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_pspin_cmd_dispatcher;
  import pspin_cmd_dispatcher_pkg::*;

  localparam int NR = 8, NI = 3, MAXI = 4, FD = 4, CW = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR-1:0]            cmd_valid, cmd_ready;
  pspin_cmd_t [NR-1:0]      cmd;
  logic [NI-1:0]            intf_valid, intf_ready;
  pspin_cmd_t [NI-1:0]      intf_cmd;
  logic [NI-1:0]            cmpl_valid, cmpl_ready;
  pspin_cmd_resp_t [NI-1:0] cmpl;
  logic                     resp_valid;
  pspin_cmd_resp_t          resp;
  logic [NR-1:0][CW-1:0]    inflight;
  logic                     err;

  always #5 clk = ~clk;

  pspin_cmd_dispatcher #(
    .NUM_REQ(NR), .NUM_INTF(NI), .MAX_INFLIGHT(MAXI), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_i(cmd),
    .intf_valid_o(intf_valid), .intf_ready_i(intf_ready), .intf_cmd_o(intf_cmd),
    .cmpl_valid_i(cmpl_valid), .cmpl_ready_o(cmpl_ready), .cmpl_i(cmpl),
    .resp_valid_o(resp_valid), .resp_o(resp),
    .inflight_o(inflight), .err_o(err)
  );

  int n_chk = 0, n_fail = 0;

  // Reference state: one queue per interface, outstanding count per requester.
  pspin_cmd_t      mq [NI][$];
  int              m_inf [NR];
  int              m_rptr, m_cptr;
  bit              m_rv, m_err;
  pspin_cmd_resp_t m_resp;
  int              last_w, last_c;
  logic [NR-1:0]   s_rdy;
  logic [NI-1:0]   s_crdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pspin_cmd_t mk(input int core, input int intf);
    pspin_cmd_t c;
    c.cmd_id.core_id  = CORE_ID_W'(core);
    c.cmd_id.local_id = LOCAL_ID_W'($urandom);
    c.intf_id         = INTF_ID_W'(intf);
    c.data            = $urandom;
    return c;
  endfunction

  function automatic pspin_cmd_resp_t mkr(input int core);
    pspin_cmd_resp_t r;
    r.cmd_id.core_id  = CORE_ID_W'(core);
    r.cmd_id.local_id = LOCAL_ID_W'($urandom);
    r.imm_data        = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) mq[k].delete();
    for (int i = 0; i < NR; i++) m_inf[i] = 0;
    m_rptr = 0; m_cptr = 0; m_rv = 0; m_err = 0; m_resp = '0;
    last_w = -1; last_c = -1;
  endfunction

  // Called at a negedge with inputs already driven; compares, advances the model, returns at next negedge.
  task automatic step();
    int w, c, idx, owner, dec;
    bit bad, err_n;
    logic [NR-1:0] erdy;
    logic [NI-1:0] ecr;
    #1;
    s_rdy  = cmd_ready;
    s_crdy = cmpl_ready;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_rptr + k) % NR;
      bad = int'(cmd[idx].intf_id) >= NI;
      if (w < 0 && cmd_valid[idx] &&
          (bad || (m_inf[idx] < MAXI && mq[cmd[idx].intf_id].size() < FD))) w = idx;
    end
    c = -1;
    for (int k = 0; k < NI; k++) begin
      idx = (m_cptr + k) % NI;
      if (c < 0 && cmpl_valid[idx]) c = idx;
    end
    erdy = '0; if (w >= 0) erdy[w] = 1'b1;
    ecr  = '0; if (c >= 0) ecr[c]  = 1'b1;
    check("cmd_ready", cmd_ready, erdy);
    check("cmpl_ready", cmpl_ready, ecr);
    for (int k = 0; k < NI; k++) begin
      check("intf_valid", intf_valid[k], mq[k].size() > 0);
      if (mq[k].size() > 0) check("intf_cmd", intf_cmd[k], mq[k][0]);
    end
    check("resp_valid", resp_valid, m_rv);
    if (m_rv) check("resp", resp, m_resp);
    check("err", err, m_err);
    for (int i = 0; i < NR; i++) check("inflight", inflight[i], m_inf[i]);

    err_n = 0;
    dec = -1;
    for (int k = 0; k < NI; k++)
      if (mq[k].size() > 0 && intf_ready[k]) void'(mq[k].pop_front());
    if (c >= 0) begin
      owner = int'(cmpl[c].cmd_id.core_id);
      if (owner < NR && m_inf[owner] > 0) dec = owner;
      else err_n = 1;
      m_resp = cmpl[c];
      m_cptr = (c + 1) % NI;
    end
    m_rv = (c >= 0);
    if (w >= 0) begin
      if (int'(cmd[w].intf_id) >= NI) err_n = 1;
      else begin
        mq[cmd[w].intf_id].push_back(cmd[w]);
        m_inf[w]++;
      end
      m_rptr = (w + 1) % NR;
    end
    if (dec >= 0) m_inf[dec]--;
    m_err = err_n;
    last_w = w; last_c = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cmd_valid = '0; cmpl_valid = '0; intf_ready = '0;
    rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_intf_valid", intf_valid, 0);
    check("rst_intf_cmd", {22'd0, intf_cmd[0]}, 0);
    check("rst_cmpl_ready", cmpl_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp", resp, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    int core;
    for (int i = 0; i < NR; i++) begin
      cmd_valid[i] = ($urandom_range(0, 2) != 0);
      cmd[i] = mk(i, ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NI-1));
    end
    intf_ready = NI'($urandom);
    for (int k = 0; k < NI; k++) begin
      if (cmpl_valid[k] && last_c != k) begin
        // interface holds its completion until it is taken
      end else if ($urandom_range(0, 2) == 0) begin
        core = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, NR-1);
        cmpl_valid[k] = 1'b1;
        cmpl[k] = mkr(core);
      end else cmpl_valid[k] = 1'b0;
    end
  endtask

  initial begin
    int acc;
    rst_n = 1'b0;
    cmd_valid = '0; cmd = '0; intf_ready = '0; cmpl_valid = '0; cmpl = '0;
    model_reset();
    @(negedge clk);

    // 1: single command, same-cycle ready, dispatch next cycle
    do_reset();
    cmd[0] = mk(0, 1); cmd_valid = 8'h01; intf_ready = '1;
    #1 check("t1_ready_same_cycle", cmd_ready[0], 1);
    step();
    cmd_valid = '0;
    check("t1_intf1_valid", intf_valid[1], 1);
    check("t1_inflight0", inflight[0], 1);
    step();

    // 2: inflight limit and FIFO full, then one completion plus one pop frees a slot
    do_reset();
    intf_ready = '0; cmd[3] = mk(3, 2); cmd_valid = 8'h08; acc = 0;
    for (int j = 0; j < 6; j++) begin step(); acc += int'(s_rdy[3]); end
    check("t2_accepted", acc, 4);
    check("t2_inflight3", inflight[3], 4);
    cmpl[2] = mkr(3); cmpl_valid = 3'b100; intf_ready = 3'b100;
    step(); acc += int'(s_rdy[3]);
    cmpl_valid = '0; intf_ready = '0;
    step(); acc += int'(s_rdy[3]);
    check("t2_fifth_accepted", acc, 5);
    cmd_valid = '0;
    step();

    // 3: all requesters contending, strict rotation
    do_reset();
    intf_ready = 3'b001;
    for (int i = 0; i < NR; i++) cmd[i] = mk(i, 0);
    cmd_valid = '1;
    for (int j = 0; j < 16; j++) begin
      step();
      check("t3_grant_order", s_rdy, 64'(1) << (j % NR));
    end
    cmd_valid = '0;
    step();

    // 4: two completions together resolve on consecutive cycles
    do_reset();
    intf_ready = '1; cmd[1] = mk(1, 0); cmd[4] = mk(4, 0); cmd_valid = 8'h12;
    step(); step();
    cmd_valid = '0;
    cmpl[0] = mkr(1); cmpl[2] = mkr(4); cmpl_valid = 3'b101;
    step();
    check("t4_first_grant", s_crdy, 3'b001);
    cmpl_valid = 3'b100;
    check("t4_resp1_valid", resp_valid, 1);
    check("t4_resp1_core", resp.cmd_id.core_id, 1);
    step();
    cmpl_valid = '0;
    check("t4_resp2_valid", resp_valid, 1);
    check("t4_resp2_core", resp.cmd_id.core_id, 4);
    check("t4_inflight1", inflight[1], 0);
    check("t4_inflight4", inflight[4], 0);
    step();

    // 5: bad intf_id and unmatched completion
    do_reset();
    intf_ready = '0; cmd[5] = mk(5, 3); cmd_valid = 8'h20;
    #1 check("t5_bad_ready", cmd_ready[5], 1);
    step();
    cmd_valid = '0;
    check("t5_err_cmd", err, 1);
    check("t5_no_push", intf_valid, 0);
    check("t5_no_credit", inflight[5], 0);
    cmpl[1] = mkr(2); cmpl_valid = 3'b010;
    step();
    cmpl_valid = '0;
    check("t5_err_cmpl", err, 1);
    check("t5_resp_fwd", resp_valid, 1);
    check("t5_resp_core", resp.cmd_id.core_id, 2);
    step();
    check("t5_err_cleared", err, 0);

    // Randomized traffic, a mid-traffic reset with FIFOs loaded, then more traffic
    do_reset();
    for (int j = 0; j < 800; j++) begin rand_drive(); step(); end
    for (int j = 0; j < 6; j++) begin rand_drive(); intf_ready = '0; step(); end
    do_reset();
    step();
    check("t6_fifos_empty", intf_valid, 0);
    check("t6_counters_zero", inflight, 0);
    for (int j = 0; j < 1500; j++) begin rand_drive(); step(); end
    cmd_valid = '0; cmpl_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
